// File: rtl/systolic_array_os_pkg.sv
// Shared types and helpers for the TPU systolic datapath.
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Accumulator width: full product plus enough headroom for k_max additions.
  function automatic int acc_w_f(input int data_w, input int k_max);
    return 2 * data_w + $clog2(k_max + 1);
  endfunction

endpackage

// File: rtl/systolic_array_os_if.sv
// Job/operand/result bus of the output-stationary systolic array.
interface systolic_array_os_if
  import tpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N      = 4,
  parameter int K_MAX  = 255
);
  localparam int ACC_W = acc_w_f(DATA_W, K_MAX);
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int IW    = $clog2(N);

  logic                  start;
  logic [KW-1:0]         k_len;
  logic                  in_valid;
  logic                  in_ready;
  logic [N*DATA_W-1:0]   a_col;
  logic [N*DATA_W-1:0]   b_row;
  logic                  out_valid;
  logic                  out_ready;
  logic [N*ACC_W-1:0]    out_row;
  logic [IW-1:0]         out_idx;
  logic                  busy;
  logic                  done;

  modport master (
    output start, k_len, in_valid, a_col, b_row, out_ready,
    input  in_ready, out_valid, out_row, out_idx, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, a_col, b_row, out_ready,
    output in_ready, out_valid, out_row, out_idx, busy, done
  );

endinterface

// File: rtl/systolic_array_os_mac_pe.sv
// Output-stationary processing element: forwards a right and b down one hop
// per cycle and accumulates a*b whenever the arriving operands are tagged valid.
module mac_pe #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic                     a_vld_in,
  input  logic signed [DATA_W-1:0] b_in,
  input  logic                     b_vld_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic                     a_vld_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic                     b_vld_out,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PW = 2 * DATA_W;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [PW-1:0] p);
    return {{(ACC_W - PW){p[PW-1]}}, p};
  endfunction

  logic signed [PW-1:0]     prod_p0;
  logic signed [DATA_W-1:0] a_p0;
  logic signed [DATA_W-1:0] b_p0;
  logic                     vld_a_p0;
  logic                     vld_b_p0;
  logic signed [ACC_W-1:0]  acc_p0;

  assign prod_p0 = a_in * b_in;

  // Stage 0 -> 1: operand forwarding registers and the stationary accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_p0     <= '0;
      b_p0     <= '0;
      vld_a_p0 <= 1'b0;
      vld_b_p0 <= 1'b0;
      acc_p0   <= '0;
    end else begin
      a_p0     <= a_in;
      b_p0     <= b_in;
      vld_a_p0 <= a_vld_in;
      vld_b_p0 <= b_vld_in;
      if (clr)
        acc_p0 <= '0;
      else if (a_vld_in && b_vld_in)
        acc_p0 <= acc_p0 + sext(prod_p0);
    end
  end

  assign a_out     = a_p0;
  assign a_vld_out = vld_a_p0;
  assign b_out     = b_p0;
  assign b_vld_out = vld_b_p0;
  assign acc       = acc_p0;

endmodule

// File: rtl/systolic_array_os.sv
// N x N output-stationary systolic matrix multiply with input skew,
// start/busy/done control and a one-row-per-beat ready/valid result drain.
module systolic_array_os
  import tpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N      = 4,
  parameter int K_MAX  = 255
) (
  input logic                clk,
  input logic                rst,
  systolic_array_os_if.slave bus
);

  localparam int ACC_W = acc_w_f(DATA_W, K_MAX);
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int IW    = $clog2(N);
  localparam int FW    = $clog2(2 * N);

  // Lengths beyond the array's headroom are clipped so the accumulator cannot wrap.
  function automatic logic [KW-1:0] sat_klen(input logic [KW-1:0] k);
    if (32'(k) > K_MAX)
      return KW'(K_MAX);
    return k;
  endfunction

  state_t           state, state_nxt;
  logic [KW-1:0]    k_len_q;
  logic [KW-1:0]    beat_cnt;
  logic [FW-1:0]    flush_cnt;
  logic [IW-1:0]    out_idx_q;
  logic             done_q;

  logic go, in_hs, out_hs, last_beat, flush_last, out_last;

  // start is ignored in the cycle done is pulsing
  assign go         = (state == IDLE) && bus.start && !done_q;
  assign in_hs      = (state == LOAD) && bus.in_valid;
  assign out_hs     = (state == DRAIN) && bus.out_ready;
  assign last_beat  = in_hs && ((beat_cnt + KW'(1)) == k_len_q);
  assign flush_last = (flush_cnt == FW'(2 * N - 2));
  assign out_last   = (out_idx_q == IW'(N - 1));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (go) state_nxt = (sat_klen(bus.k_len) == '0) ? DRAIN : LOAD;
      LOAD:  if (last_beat) state_nxt = FLUSH;
      FLUSH: if (flush_last) state_nxt = DRAIN;
      DRAIN: if (out_hs && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    bus.in_ready  = (state == LOAD);
    bus.out_valid = (state == DRAIN);
    bus.busy      = (state != IDLE);
  end

  // Job length, beat/flush counters, drain row index and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_len_q   <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      out_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      if (go) begin
        k_len_q  <= sat_klen(bus.k_len);
        beat_cnt <= '0;
      end else if (in_hs) begin
        beat_cnt <= beat_cnt + KW'(1);
      end
      if (state == FLUSH) flush_cnt <= flush_cnt + FW'(1);
      else                flush_cnt <= '0;
      if (out_hs) out_idx_q <= out_last ? '0 : out_idx_q + IW'(1);
      done_q <= out_hs && out_last;
    end
  end

  assign bus.out_idx = out_idx_q;
  assign bus.done    = done_q;

  // Operands entering the skew; bubbles carry zero data and a cleared tag.
  logic signed [DATA_W-1:0] a_feed [N];
  logic signed [DATA_W-1:0] b_feed [N];
  logic signed [DATA_W-1:0] a_edge [N];
  logic signed [DATA_W-1:0] b_edge [N];
  logic                     a_edge_vld [N];
  logic                     b_edge_vld [N];

  logic signed [DATA_W-1:0] a_h  [N][N+1];
  logic                     a_hv [N][N+1];
  logic signed [DATA_W-1:0] b_v  [N+1][N];
  logic                     b_vv [N+1][N];
  logic signed [ACC_W-1:0]  acc_m [N][N];

  for (genvar i = 0; i < N; i++) begin : g_skew
    assign a_feed[i] = in_hs ? $signed(bus.a_col[i*DATA_W +: DATA_W]) : '0;
    assign b_feed[i] = in_hs ? $signed(bus.b_row[i*DATA_W +: DATA_W]) : '0;

    if (i == 0) begin : g_direct
      assign a_edge[i]     = a_feed[i];
      assign b_edge[i]     = b_feed[i];
      assign a_edge_vld[i] = in_hs;
      assign b_edge_vld[i] = in_hs;
    end else begin : g_delay
      logic signed [DATA_W-1:0] a_dly_p [i];
      logic signed [DATA_W-1:0] b_dly_p [i];
      logic                     vld_dly_p [i];

      // Skew line: A row i and B column i both lag the feed by i cycles.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int d = 0; d < i; d++) begin
            a_dly_p[d]   <= '0;
            b_dly_p[d]   <= '0;
            vld_dly_p[d] <= 1'b0;
          end
        end else begin
          a_dly_p[0]   <= a_feed[i];
          b_dly_p[0]   <= b_feed[i];
          vld_dly_p[0] <= in_hs;
          for (int d = 1; d < i; d++) begin
            a_dly_p[d]   <= a_dly_p[d-1];
            b_dly_p[d]   <= b_dly_p[d-1];
            vld_dly_p[d] <= vld_dly_p[d-1];
          end
        end
      end

      assign a_edge[i]     = a_dly_p[i-1];
      assign b_edge[i]     = b_dly_p[i-1];
      assign a_edge_vld[i] = vld_dly_p[i-1];
      assign b_edge_vld[i] = vld_dly_p[i-1];
    end

    assign a_h[i][0]  = a_edge[i];
    assign a_hv[i][0] = a_edge_vld[i];
    assign b_v[0][i]  = b_edge[i];
    assign b_vv[0][i] = b_edge_vld[i];
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      mac_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk       (clk),
        .rst       (rst),
        .clr       (go),
        .a_in      (a_h[r][c]),
        .a_vld_in  (a_hv[r][c]),
        .b_in      (b_v[r][c]),
        .b_vld_in  (b_vv[r][c]),
        .a_out     (a_h[r][c+1]),
        .a_vld_out (a_hv[r][c+1]),
        .b_out     (b_v[r+1][c]),
        .b_vld_out (b_vv[r+1][c]),
        .acc       (acc_m[r][c])
      );
    end
  end

  // Result row mux: only the selected accumulator row is visible, and only in DRAIN.
  always_comb begin
    bus.out_row = '0;
    if (state == DRAIN)
      for (int j = 0; j < N; j++)
        bus.out_row[j*ACC_W +: ACC_W] = acc_m[out_idx_q][j];
  end

endmodule

// File: tb/tb_systolic_array_os.sv
// Directed bench for systolic_array_os (N=4, DATA_W=16, K_MAX=255).
module tb_systolic_array_os;
  import tpu_pkg::*;

  localparam int DATA_W = 16;
  localparam int N      = 4;
  localparam int K_MAX  = 255;
  localparam int ACC_W  = acc_w_f(DATA_W, K_MAX);
  localparam int RW     = N * ACC_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_array_os_if #(.DATA_W(DATA_W), .N(N), .K_MAX(K_MAX)) bus ();

  systolic_array_os #(.DATA_W(DATA_W), .N(N), .K_MAX(K_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic signed [DATA_W-1:0] amat [N][K_MAX+1];
  logic signed [DATA_W-1:0] bmat [K_MAX+1][N];
  longint                   expc [N][N];

  typedef struct {
    int     k;
    int     av;
    int     bv;
    longint c;
    int     gap;
    int     stall;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [RW-1:0] got, input logic [RW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  function automatic logic [RW-1:0] exp_row(input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*ACC_W +: ACC_W] = ACC_W'(expc[r][j]);
    return v;
  endfunction

  task automatic fill_const(input int k, input int av, input int bv, input longint c);
    for (int kk = 0; kk < k; kk++)
      for (int i = 0; i < N; i++) begin
        amat[i][kk] = DATA_W'(av);
        bmat[kk][i] = DATA_W'(bv);
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) expc[i][j] = c;
  endtask

  task automatic ref_model(input int k);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        expc[i][j] = 0;
        for (int kk = 0; kk < k; kk++)
          expc[i][j] += longint'(amat[i][kk]) * longint'(bmat[kk][j]);
      end
  endtask

  task automatic drive_beat(input int beat);
    for (int i = 0; i < N; i++) begin
      bus.a_col[i*DATA_W +: DATA_W] = amat[i][beat];
      bus.b_row[i*DATA_W +: DATA_W] = bmat[beat][i];
    end
  endtask

  // Runs one job from IDLE and ends at a negedge with the DUT back in IDLE.
  task automatic run_job(input string nm, input int k, input int gap, input int stall);
    int            beat, cyc, lat;
    logic          acc_ok, ready_gap, seen_ready, stable;
    logic [RW-1:0] r0;
    logic [1:0]    i0;
    bus.k_len = 8'(k);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    beat = 0; cyc = 0; ready_gap = 1'b0;
    while (beat < k && cyc < 4 * k + 20) begin
      bus.in_valid = (gap == 0) || (cyc % 2 == 0);
      drive_beat(beat);
      @(negedge clk);
      acc_ok = bus.in_valid && bus.in_ready;
      if (!bus.in_ready) ready_gap = 1'b1;
      @(posedge clk); #1;
      if (acc_ok) beat++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.a_col    = '0;
    bus.b_row    = '0;
    chk({nm, " beats"}, RW'(beat), RW'(k));
    chk({nm, " in_ready in LOAD"}, RW'(ready_gap), '0);
    lat = 0; seen_ready = 1'b0;
    while (lat < 100) begin
      @(negedge clk);
      if (bus.out_valid) break;
      if (bus.in_ready) seen_ready = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, RW'(lat), RW'((k > 0) ? 2 * N - 1 : 0));
    chk({nm, " in_ready outside LOAD"}, RW'(seen_ready), '0);
    for (int r = 0; r < N; r++) begin
      r0 = bus.out_row; i0 = bus.out_idx; stable = 1'b1;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        @(negedge clk);
        if (bus.out_row !== r0 || bus.out_idx !== i0 || !bus.out_valid) stable = 1'b0;
      end
      if (stall > 0) chk($sformatf("%s stall row %0d", nm, r), RW'(stable), RW'(1));
      bus.out_ready = 1'b1;
      chk($sformatf("%s valid/idx %0d", nm, r), RW'({bus.out_valid, bus.out_idx}), RW'({1'b1, 2'(r)}));
      chk($sformatf("%s row %0d", nm, r), bus.out_row, exp_row(r));
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      if (r < N - 1) @(negedge clk);
    end
    // start during the done cycle must be ignored
    bus.start = 1'b1;
    @(negedge clk);
    chk({nm, " done/busy"}, RW'({bus.done, bus.busy}), RW'(2'b10));
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk({nm, " after done"}, RW'({bus.done, bus.busy, bus.out_valid}), '0);
  endtask

  initial begin
    tbl[0] = '{1,   3,      5,      64'sd15,            0, 0};
    tbl[1] = '{2,   100,    -100,   -64'sd20000,        0, 0};
    tbl[2] = '{3,   -2,     7,      -64'sd42,           0, 5};
    tbl[3] = '{8,   32767,  -32768, -64'sd8589672448,   1, 0};
    tbl[4] = '{0,   5,      5,      64'sd0,             0, 0};
    tbl[5] = '{255, -32768, -32768, 64'sd273804165120,  0, 0};

    rst = 1'b1;
    bus.start = 1'b0; bus.k_len = '0; bus.in_valid = 1'b0;
    bus.a_col = '0; bus.b_row = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ctl", RW'({bus.in_ready, bus.out_valid, bus.out_idx, bus.busy, bus.done}), '0);
    chk("reset out_row", bus.out_row, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle in_ready", RW'({bus.in_ready, bus.busy}), '0);

    // 2x2 corner of the array: A=[[1,2],[3,4]], B=identity, k=2
    fill_const(2, 0, 0, 0);
    amat[0][0] = 1; amat[0][1] = 2; amat[1][0] = 3; amat[1][1] = 4;
    bmat[0][0] = 1; bmat[1][1] = 1;
    expc[0][0] = 1; expc[0][1] = 2; expc[1][0] = 3; expc[1][1] = 4;
    run_job("small2x2", 2, 0, 0);

    for (int t = 0; t < 6; t++) begin
      fill_const(tbl[t].k, tbl[t].av, tbl[t].bv, tbl[t].c);
      run_job($sformatf("vec%0d", t), tbl[t].k, tbl[t].gap, tbl[t].stall);
    end

    // random signed operands with in_valid toggling
    for (int kk = 0; kk < 8; kk++)
      for (int i = 0; i < N; i++) begin
        amat[i][kk] = DATA_W'($urandom);
        bmat[kk][i] = DATA_W'($urandom);
      end
    ref_model(8);
    run_job("random", 8, 1, 1);

    // abort a job during FLUSH, then check a clean identity job
    fill_const(4, 7, 9, 0);
    bus.k_len = 8'd4; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int kk = 0; kk < 4; kk++) begin
      bus.in_valid = 1'b1; drive_beat(kk);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.a_col = '0; bus.b_row = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort ctl", RW'({bus.in_ready, bus.out_valid, bus.out_idx, bus.busy, bus.done}), '0);
    chk("abort out_row", bus.out_row, '0);
    rst = 1'b0;
    for (int kk = 0; kk < 4; kk++)
      for (int i = 0; i < N; i++) begin
        amat[i][kk] = (i == kk) ? 16'sd1 : 16'sd0;
        bmat[kk][i] = (i == kk) ? 16'sd1 : 16'sd0;
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) expc[i][j] = (i == j) ? 1 : 0;
    run_job("identity", 4, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
